// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
// Holds the stall encodings, the Stop/NoStop bit values, the eret exception
// code, the default exception vector, the FSM state type and small helpers.
package pipe_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // stall bit order: {WB, MEM/WB, EX/MEM, ID/EX, IF/ID, PC}
  localparam logic [5:0] STALL_NONE = {NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP};
  localparam logic [5:0] STALL_IF   = {NOSTOP, NOSTOP, NOSTOP, NOSTOP, STOP,   STOP};
  localparam logic [5:0] STALL_ID   = {NOSTOP, NOSTOP, NOSTOP, STOP,   STOP,   STOP};
  localparam logic [5:0] STALL_EX   = {NOSTOP, NOSTOP, STOP,   STOP,   STOP,   STOP};
  localparam logic [5:0] STALL_MEM  = {NOSTOP, STOP,   STOP,   STOP,   STOP,   STOP};

  localparam logic [31:0] EXC_ERET           = 32'h0000000e;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h00000020;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Deepest requesting stage wins: it must freeze everything upstream of it.
  function automatic logic [5:0] stall_decode(input logic req_if,
                                              input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

  // eret returns to the saved EPC; every other exception enters the vector.
  function automatic logic [31:0] redirect_pc(input logic [31:0] exc,
                                              input logic [31:0] epc,
                                              input logic [31:0] vec);
    return (exc == EXC_ERET) ? epc : vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// stall_watchdog: flags a pipeline that has been stalled for LIMIT
// consecutive cycles.
// Ports:
//   clk          in  rising-edge clock
//   rst          in  synchronous active-high reset
//   stall_active in  pipeline is stalled this cycle
//   clear        in  restart the count (no stall, or flush)
//   timeout      out stalled for LIMIT consecutive cycles; held until clear
module stall_watchdog #(
  parameter logic [15:0] LIMIT = 16'd1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  input  logic clear,
  output logic timeout
);

  // Counts down from LIMIT; reaching zero is the terminal count. Sticking at
  // zero gives the saturating behaviour of an up-counter capped at LIMIT.
  logic [15:0] remain;

  always_ff @(posedge clk) begin
    if (rst) begin
      remain <= LIMIT;
    end else if (clear) begin
      remain <= LIMIT;
    end else if (stall_active && (remain != 16'd0)) begin
      remain <= remain - 16'd1;
    end
  end

  assign timeout = !rst && (remain == 16'd0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
// Decodes per-stage stall requests, redirects fetch on exceptions (deferring
// the flush while MEM is stalled) and watches for stalls that never end.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   stallreq_from_if/id/ex/mem  per-stage stall requests
//   excepttype               MEM-stage exception code (0 = none, 0xe = eret)
//   cp0_epc                  eret return address
//   stall[5:0]               per-register Stop bits (bit0 PC .. bit5 WB)
//   flush, new_pc            clear pipeline and redirect fetch to new_pc
//   stall_timeout            stall watchdog expired
//
// state | meaning
// RUN   | normal operation; unstalled exceptions flush in the same cycle
// PEND  | exception captured while MEM stalled; waiting for MEM to release
// FLUSH | one-cycle flush using the captured exception
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
  parameter logic [15:0] STALL_LIMIT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
);

  state_t      state_q, state_d;
  logic [31:0] exc_q, epc_q;
  logic        latch_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      exc_q   <= 32'd0;
      epc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        exc_q <= excepttype;
        epc_q <= cp0_epc;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    flush    = 1'b0;
    new_pc   = 32'd0;
    stall    = stall_decode(stallreq_from_if, stallreq_from_id,
                            stallreq_from_ex, stallreq_from_mem);
    case (state_q)
      ST_RUN: begin
        if (excepttype != 32'd0) begin
          if (stallreq_from_mem) begin
            latch_en = 1'b1;
            state_d  = ST_PEND;
          end else begin
            flush  = 1'b1;
            new_pc = redirect_pc(excepttype, cp0_epc, EXC_VECTOR);
          end
        end
      end
      ST_PEND: begin
        // Later exceptions are ignored: the first one captured is the one taken.
        if (!stallreq_from_mem) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        new_pc  = redirect_pc(exc_q, epc_q, EXC_VECTOR);
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (flush) stall = STALL_NONE;
    if (rst) begin
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = 32'd0;
    end
  end

  stall_watchdog #(
    .LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stall_active (stall != STALL_NONE),
    .clear        (flush || (stall == STALL_NONE)),
    .timeout      (stall_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .excepttype        (excepttype),
    .cp0_epc           (cp0_epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_timeout     (stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [5:0] e_stall, input logic e_flush,
                      input logic [31:0] e_pc, input logic e_to);
    chk({tag, ".stall"},   {26'd0, stall},         {26'd0, e_stall});
    chk({tag, ".flush"},   {31'd0, flush},         {31'd0, e_flush});
    chk({tag, ".new_pc"},  new_pc,                 e_pc);
    chk({tag, ".timeout"}, {31'd0, stall_timeout}, {31'd0, e_to});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
    stallreq_from_if  = r_if;
    stallreq_from_id  = r_id;
    stallreq_from_ex  = r_ex;
    stallreq_from_mem = r_mem;
  endtask

  initial begin
    rst = 1'b1;
    set_req(1'b1, 1'b0, 1'b0, 1'b1);
    excepttype = 32'h8;
    cp0_epc    = 32'h0;

    // reset forces outputs low even with requests present
    #1; outs("rst_comb", 6'h00, 1'b0, 32'h0, 1'b0);
    next_cycle(); #1; outs("rst_hold", 6'h00, 1'b0, 32'h0, 1'b0);
    next_cycle(); rst = 1'b0; set_req(1'b0, 1'b0, 1'b0, 1'b0); excepttype = 32'h0;
    #1; outs("idle", 6'h00, 1'b0, 32'h0, 1'b0);

    // stall decode
    next_cycle(); set_req(1'b1, 1'b0, 1'b0, 1'b0); #1; chk("dec_if", {26'd0, stall}, 32'h03);
    next_cycle(); set_req(1'b0, 1'b1, 1'b0, 1'b0); #1; chk("dec_id", {26'd0, stall}, 32'h07);
    next_cycle(); set_req(1'b0, 1'b1, 1'b1, 1'b0); #1; outs("dec_id_ex", 6'h0f, 1'b0, 32'h0, 1'b0);
    next_cycle(); set_req(1'b0, 1'b0, 1'b0, 1'b1); #1; chk("dec_mem", {26'd0, stall}, 32'h1f);
    next_cycle(); set_req(1'b1, 1'b1, 1'b1, 1'b1); #1; chk("dec_all", {26'd0, stall}, 32'h1f);
    next_cycle(); set_req(1'b0, 1'b0, 1'b0, 1'b0); #1; chk("dec_none", {26'd0, stall}, 32'h00);

    // immediate exception flush, flush overrides a stall request
    next_cycle(); excepttype = 32'h8; #1; outs("exc_imm", 6'h00, 1'b1, 32'h20, 1'b0);
    stallreq_from_if = 1'b1; #1; chk("exc_over_if", {26'd0, stall}, 32'h00);
    next_cycle(); excepttype = 32'h0; stallreq_from_if = 1'b0; #1;
    outs("exc_imm_after", 6'h00, 1'b0, 32'h0, 1'b0);

    // immediate eret goes to EPC
    next_cycle(); excepttype = 32'he; cp0_epc = 32'h0000abcd; #1;
    outs("eret_imm", 6'h00, 1'b1, 32'h0000abcd, 1'b0);
    next_cycle(); excepttype = 32'h0; cp0_epc = 32'h0; #1;
    outs("eret_imm_after", 6'h00, 1'b0, 32'h0, 1'b0);

    // deferred eret: MEM stalled 3 cycles
    next_cycle(); excepttype = 32'he; cp0_epc = 32'h1234; stallreq_from_mem = 1'b1; #1;
    outs("pend_c1", 6'h1f, 1'b0, 32'h0, 1'b0);
    next_cycle(); excepttype = 32'h0; cp0_epc = 32'h0; #1;
    outs("pend_c2", 6'h1f, 1'b0, 32'h0, 1'b0);
    next_cycle(); #1; outs("pend_c3", 6'h1f, 1'b0, 32'h0, 1'b0);
    next_cycle(); stallreq_from_mem = 1'b0; #1;
    outs("pend_release", 6'h00, 1'b0, 32'h0, 1'b0);
    next_cycle(); #1; outs("pend_flush", 6'h00, 1'b1, 32'h1234, 1'b0);
    next_cycle(); #1; outs("pend_after", 6'h00, 1'b0, 32'h0, 1'b0);

    // second exception during PEND is ignored
    next_cycle(); excepttype = 32'he; cp0_epc = 32'h1234; stallreq_from_mem = 1'b1; #1;
    chk("hold_c1", {26'd0, stall}, 32'h1f);
    next_cycle(); excepttype = 32'hc; cp0_epc = 32'h5555; #1;
    outs("hold_second", 6'h1f, 1'b0, 32'h0, 1'b0);
    next_cycle(); stallreq_from_mem = 1'b0; #1;
    outs("hold_release", 6'h00, 1'b0, 32'h0, 1'b0);
    next_cycle(); excepttype = 32'h0; #1;
    outs("hold_flush", 6'h00, 1'b1, 32'h1234, 1'b0);
    next_cycle(); #1; outs("hold_after", 6'h00, 1'b0, 32'h0, 1'b0);

    // reset in PEND discards the exception
    next_cycle(); excepttype = 32'h8; cp0_epc = 32'h0; stallreq_from_mem = 1'b1; #1;
    chk("rpend_c1", {26'd0, stall}, 32'h1f);
    next_cycle(); excepttype = 32'h0; rst = 1'b1; #1;
    outs("rpend_rst", 6'h00, 1'b0, 32'h0, 1'b0);
    next_cycle(); rst = 1'b0; stallreq_from_mem = 1'b0; #1;
    outs("rpend_rel", 6'h00, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      next_cycle(); #1; chk("rpend_noflush", {31'd0, flush}, 32'h0);
    end

    // reset in FLUSH discards the exception
    next_cycle(); excepttype = 32'he; cp0_epc = 32'h1234; stallreq_from_mem = 1'b1; #1;
    chk("rflush_c1", {26'd0, stall}, 32'h1f);
    next_cycle(); excepttype = 32'h0; stallreq_from_mem = 1'b0; #1;
    chk("rflush_rel", {31'd0, flush}, 32'h0);
    next_cycle(); rst = 1'b1; #1;
    outs("rflush_rst", 6'h00, 1'b0, 32'h0, 1'b0);
    next_cycle(); rst = 1'b0; #1; chk("rflush_noflush0", {31'd0, flush}, 32'h0);
    next_cycle(); #1; chk("rflush_noflush1", {31'd0, flush}, 32'h0);

    // watchdog
    next_cycle(); stallreq_from_if = 1'b1; #1;
    outs("wd_start", 6'h03, 1'b0, 32'h0, 1'b0);
    repeat (1023) next_cycle();
    #1; chk("wd_1023", {31'd0, stall_timeout}, 32'h0);
    next_cycle(); #1; chk("wd_1024", {31'd0, stall_timeout}, 32'h1);
    repeat (3) next_cycle();
    #1; chk("wd_sat", {31'd0, stall_timeout}, 32'h1);
    stallreq_from_if = 1'b0; #1;
    chk("wd_drop_same", {31'd0, stall_timeout}, 32'h1);
    next_cycle(); #1; chk("wd_drop_next", {31'd0, stall_timeout}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
